// File: rtl/pio_apb_bridge.sv
// APB3 completer for the PIO register file: decodes offsets, issues register-file
// strobes and performs XOR/SET/CLR alias writes as a two-cycle read-modify-write.
module pio_apb_bridge #(
  parameter int unsigned ADDR_W   = 14,
  parameter bit          ALIAS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [9:0]        rf_addr,
  output logic [31:0]       rf_wdata,
  output logic              rf_write_en,
  input  logic [31:0]       rf_rdata
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OFF_W   = 10;
  localparam int unsigned ALIAS_W = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A1   = 3'd1,
    S_A2   = 3'd2,
    S_A3   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ALIAS_W-1:0]  alias_q, alias_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [OFF_W-1:0]    rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                rf_write_en_q, rf_write_en_d;

  logic [OFF_W-1:0]    off_c;
  logic [ALIAS_W-1:0]  alias_sel_c;
  logic                mapped_c;
  logic                dec_err_c;
  logic [DATA_W-1:0]   rmw_data_c;

  // Address decode of the current setup-phase address
  always_comb begin
    off_c       = paddr[OFF_W-1:0];
    alias_sel_c = paddr[13:12];
    mapped_c    = (off_c <= 10'h00C) ||
                  (off_c == 10'h030) ||
                  ((off_c >= 10'h038) && (off_c <= 10'h044)) ||
                  ((off_c >= 10'h0C8) && (off_c <= 10'h140));
    dec_err_c   = (paddr[1:0] != 2'd0) ||
                  (paddr[11:10] != 2'd0) ||
                  ((alias_sel_c != 2'd0) && !ALIAS_EN) ||
                  !mapped_c;
  end

  // Alias write value from the register-file contents read during A1
  always_comb begin
    unique case (alias_q)
      2'd1:    rmw_data_c = rf_rdata ^ wdata_q;
      2'd2:    rmw_data_c = rf_rdata | wdata_q;
      2'd3:    rmw_data_c = rf_rdata & ~wdata_q;
      default: rmw_data_c = rf_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    alias_d       = alias_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    prdata_d      = prdata_q;
    pready_d      = 1'b0;
    pslverr_d     = 1'b0;
    rf_addr_d     = rf_addr_q;
    rf_wdata_d    = rf_wdata_q;
    rf_write_en_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          alias_d   = alias_sel_c;
          write_d   = pwrite;
          wdata_d   = pwdata;
          err_d     = dec_err_c;
          rf_addr_d = off_c;
          state_d   = S_A1;
          // Plain writes strobe during A1, so the strobe is launched here
          if (!dec_err_c && pwrite && (alias_sel_c == 2'd0)) begin
            rf_write_en_d = 1'b1;
            rf_wdata_d    = pwdata;
          end
        end
      end
      S_A1: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (err_q) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          if (!write_q) prdata_d = '0;
          state_d   = S_RESP;
        end else if (!write_q) begin
          prdata_d = rf_rdata;
          pready_d = 1'b1;
          state_d  = S_RESP;
        end else if (alias_q == 2'd0) begin
          pready_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          rf_wdata_d    = rmw_data_c;
          rf_write_en_d = 1'b1;
          state_d       = S_A2;
        end
      end
      S_A2: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else begin
          pready_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      alias_q       <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      err_q         <= 1'b0;
      prdata_q      <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      rf_addr_q     <= '0;
      rf_wdata_q    <= '0;
      rf_write_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alias_q       <= alias_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      err_q         <= err_d;
      prdata_q      <= prdata_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      rf_addr_q     <= rf_addr_d;
      rf_wdata_q    <= rf_wdata_d;
      rf_write_en_q <= rf_write_en_d;
    end
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign rf_addr     = rf_addr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_write_en = rf_write_en_q;

endmodule

// File: tb/tb_pio_apb_bridge.sv
// Bench for pio_apb_bridge: directed vector table, hand-written corner sequences and
// random transfers checked against a register-level reference model.
module tb_pio_apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [13:0] paddr;
  logic [31:0] pwdata;

  logic [31:0] prdata, rf_wdata, rf_rdata;
  logic        pready, pslverr, rf_write_en;
  logic [9:0]  rf_addr;

  logic [31:0] na_prdata, na_rf_wdata, na_rf_rdata;
  logic        na_pready, na_pslverr, na_rf_write_en;
  logic [9:0]  na_rf_addr;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pio_apb_bridge #(.ADDR_W(14), .ALIAS_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_write_en(rf_write_en), .rf_rdata(rf_rdata)
  );

  pio_apb_bridge #(.ADDR_W(14), .ALIAS_EN(1'b0)) u_dut_na (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(na_prdata), .pready(na_pready),
    .pslverr(na_pslverr), .rf_addr(na_rf_addr), .rf_wdata(na_rf_wdata),
    .rf_write_en(na_rf_write_en), .rf_rdata(na_rf_rdata)
  );

  // Register file model seen by the main instance
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (rf_write_en) mem[rf_addr[9:2]] <= rf_wdata;
  end
  assign rf_rdata    = mem[rf_addr[9:2]];
  assign na_rf_rdata = {na_rf_addr, 22'h15A5A};

  typedef struct {
    logic        done;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
    int          strobes;
    logic [9:0]  s_addr;
    logic [31:0] s_data;
    logic        na_done;
    logic        na_err;
    int          na_strobes;
    logic [31:0] na_s_data;
    logic [31:0] na_rdata;
  } res_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          strobes;
    logic [31:0] s_data;
    int          cycles;
    logic        na_err;
    int          na_strobes;
    logic [31:0] na_rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] preload;
    logic        err;
    logic [31:0] rdata;
    int          strobes;
    logic [31:0] s_data;
    int          cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Mapped register windows, inclusive byte offsets
  function automatic logic addr_err(input logic [13:0] a, input logic alias_en);
    int lo[4] = '{'h000, 'h030, 'h038, 'h0C8};
    int hi[4] = '{'h00C, 'h030, 'h044, 'h140};
    logic hit = 1'b0;
    int off = int'(a[9:0]);
    for (int k = 0; k < 4; k++) if (off >= lo[k] && off <= hi[k]) hit = 1'b1;
    return (a[1:0] != 2'd0) || (a[11:10] != 2'd0) ||
           (!alias_en && a[13:12] != 2'd0) || !hit;
  endfunction

  function automatic void fill_na(input logic wr, input logic [13:0] a, inout exp_t e);
    e.na_err     = addr_err(a, 1'b0);
    e.na_strobes = (wr && !e.na_err) ? 1 : 0;
    e.na_rdata   = {a[9:0], 22'h15A5A};
  endfunction

  // Reference model: one APB transfer against the mirrored register file
  function automatic exp_t ref_xfer(input logic wr, input logic [13:0] a, input logic [31:0] d);
    exp_t e = '{default: '0};
    int idx = int'(a[9:2]);
    e.err    = addr_err(a, 1'b1);
    e.cycles = 3;
    if (!e.err) begin
      if (!wr) begin
        e.rdata = ref_mem[idx];
      end else begin
        e.strobes = 1;
        case (a[13:12])
          2'd0: e.s_data = d;
          2'd1: e.s_data = ref_mem[idx] ^ d;
          2'd2: e.s_data = ref_mem[idx] | d;
          default: e.s_data = ref_mem[idx] & ~d;
        endcase
        if (a[13:12] != 2'd0) e.cycles = 4;
        ref_mem[idx] = e.s_data;
      end
    end
    fill_na(wr, a, e);
    return e;
  endfunction

  task automatic bus_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Full APB transfer; returns with the bus still in access phase so a caller can chain
  task automatic apb_xfer(input logic wr, input logic [13:0] a, input logic [31:0] d,
                          output res_t r);
    r = '{default: '0};
    @(negedge clk);
    check("pready_low_before_setup", 32'(pready), 32'd0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    r.cycles = 1;
    while (r.cycles < 10) begin
      @(negedge clk);
      penable = 1'b1;
      r.cycles++;
      if (rf_write_en) begin r.strobes++; r.s_addr = rf_addr; r.s_data = rf_wdata; end
      if (na_rf_write_en) begin r.na_strobes++; r.na_s_data = na_rf_wdata; end
      if (na_pready && !r.na_done) begin
        r.na_done = 1'b1; r.na_err = na_pslverr; r.na_rdata = na_prdata;
      end
      if (pready) begin
        r.done = 1'b1; r.err = pslverr; r.rdata = prdata;
        break;
      end
    end
    check("xfer_completes", 32'(r.done), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic wr, input logic [13:0] a,
                           input logic [31:0] d, input res_t r, input exp_t e);
    check({tag, ".pslverr"}, 32'(r.err), 32'(e.err));
    check({tag, ".cycles"}, 32'(r.cycles), 32'(e.cycles));
    check({tag, ".strobes"}, 32'(r.strobes), 32'(e.strobes));
    if (e.strobes != 0) begin
      check({tag, ".rf_addr"}, {22'h0, r.s_addr}, {22'h0, a[9:0]});
      check({tag, ".rf_wdata"}, r.s_data, e.s_data);
    end
    if (!wr) check({tag, ".prdata"}, r.rdata, e.rdata);
    check({tag, ".na_done"}, 32'(r.na_done), 32'd1);
    check({tag, ".na_pslverr"}, 32'(r.na_err), 32'(e.na_err));
    check({tag, ".na_strobes"}, 32'(r.na_strobes), 32'(e.na_strobes));
    if (e.na_strobes != 0) check({tag, ".na_rf_wdata"}, r.na_s_data, d);
    if (!wr && !e.na_err) check({tag, ".na_prdata"}, r.na_rdata, e.na_rdata);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".prdata"}, prdata, 32'd0);
    check({tag, ".pready"}, 32'(pready), 32'd0);
    check({tag, ".pslverr"}, 32'(pslverr), 32'd0);
    check({tag, ".rf_addr"}, {22'h0, rf_addr}, 32'd0);
    check({tag, ".rf_wdata"}, rf_wdata, 32'd0);
    check({tag, ".rf_write_en"}, 32'(rf_write_en), 32'd0);
  endtask

  initial begin
    vec_t vecs[16];
    res_t r;
    exp_t e;
    logic [13:0] a;
    logic [31:0] d;
    logic        wr;

    //          wr    addr      wdata         preload       err   rdata         str sdata         cyc
    vecs[0]  = '{1'b1, 14'h0000, 32'h0000000F, 32'h00000000, 1'b0, 32'h0,        1, 32'h0000000F, 3};
    vecs[1]  = '{1'b0, 14'h00C8, 32'h0,        32'h00010000, 1'b0, 32'h00010000, 0, 32'h0,        3};
    vecs[2]  = '{1'b1, 14'h2038, 32'h0000000F, 32'h000000F0, 1'b0, 32'h0,        1, 32'h000000FF, 4};
    vecs[3]  = '{1'b1, 14'h3038, 32'h0000000F, 32'h000000F0, 1'b0, 32'h0,        1, 32'h000000F0, 4};
    vecs[4]  = '{1'b1, 14'h1038, 32'h000000FF, 32'h000000F0, 1'b0, 32'h0,        1, 32'h0000000F, 4};
    vecs[5]  = '{1'b0, 14'h0044, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 0, 32'h0,        3};
    vecs[6]  = '{1'b1, 14'h0010, 32'h12340000, 32'h00000000, 1'b1, 32'h0,        0, 32'h0,        3};
    vecs[7]  = '{1'b0, 14'h0002, 32'h0,        32'h00000000, 1'b1, 32'h00000000, 0, 32'h0,        3};
    vecs[8]  = '{1'b1, 14'h0800, 32'h00000055, 32'h00000000, 1'b1, 32'h0,        0, 32'h0,        3};
    vecs[9]  = '{1'b0, 14'h0140, 32'h0,        32'h12345678, 1'b0, 32'h12345678, 0, 32'h0,        3};
    vecs[10] = '{1'b0, 14'h0144, 32'h0,        32'h00000000, 1'b1, 32'h00000000, 0, 32'h0,        3};
    vecs[11] = '{1'b0, 14'h2030, 32'h0,        32'hCAFE0001, 1'b0, 32'hCAFE0001, 0, 32'h0,        3};
    vecs[12] = '{1'b0, 14'h0034, 32'h0,        32'h00000000, 1'b1, 32'h00000000, 0, 32'h0,        3};
    vecs[13] = '{1'b1, 14'h00C4, 32'h00000001, 32'h00000000, 1'b1, 32'h0,        0, 32'h0,        3};
    vecs[14] = '{1'b1, 14'h000C, 32'h000000A5, 32'h00000000, 1'b0, 32'h0,        1, 32'h000000A5, 3};
    vecs[15] = '{1'b1, 14'h1000, 32'h00000003, 32'h00000005, 1'b0, 32'h0,        1, 32'h00000006, 4};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      preload(vecs[i].addr[9:2], vecs[i].preload);
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r);
      e = '{default: '0};
      e.err = vecs[i].err; e.rdata = vecs[i].rdata; e.strobes = vecs[i].strobes;
      e.s_data = vecs[i].s_data; e.cycles = vecs[i].cycles;
      fill_na(vecs[i].wr, vecs[i].addr, e);
      check_res($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e);
    end

    // Reset in A2 of a SET alias write, then a normal plain write
    preload(8'h0E, 32'h000000F0);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 14'h2038; pwdata = 32'h0000000F;
    @(negedge clk);
    penable = 1'b1;
    check("rst_a2.a1_no_strobe", 32'(rf_write_en), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_a2.after");
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("rst_a2.no_strobe", 32'(rf_write_en), 32'd0);
    check("rst_a2.no_ready", 32'(pready), 32'd0);
    e = ref_xfer(1'b1, 14'h0004, 32'h0BADF00D);
    apb_xfer(1'b1, 14'h0004, 32'h0BADF00D, r);
    check_res("post_rst_write", 1'b1, 14'h0004, 32'h0BADF00D, r, e);

    // Back-to-back writes with no idle cycle between transfers
    e = ref_xfer(1'b1, 14'h0030, 32'h11111111);
    apb_xfer(1'b1, 14'h0030, 32'h11111111, r);
    check_res("b2b_first", 1'b1, 14'h0030, 32'h11111111, r, e);
    e = ref_xfer(1'b1, 14'h0100, 32'h22222222);
    apb_xfer(1'b1, 14'h0100, 32'h22222222, r);
    check_res("b2b_second", 1'b1, 14'h0100, 32'h22222222, r, e);
    bus_idle();
    check("b2b.single_ready", 32'(pready), 32'd0);

    // Plain write abandoned in A1: the strobe already issued stands, no response
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 14'h0008; pwdata = 32'h00000077;
    @(negedge clk);
    psel = 1'b0;
    check("abort_wr.strobe", 32'(rf_write_en), 32'd1);
    check("abort_wr.addr", {22'h0, rf_addr}, 32'h008);
    ref_mem[2] = 32'h00000077;
    repeat (2) begin
      @(negedge clk);
      check("abort_wr.no_ready", 32'(pready), 32'd0);
      check("abort_wr.no_strobe", 32'(rf_write_en), 32'd0);
    end

    // Alias write abandoned in A1: no strobe at all, register unchanged
    preload(8'h02, 32'h00000001);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 14'h2008; pwdata = 32'h00000002;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_a1.no_strobe", 32'(rf_write_en), 32'd0);
      check("abort_a1.no_ready", 32'(pready), 32'd0);
    end
    e = ref_xfer(1'b0, 14'h0008, 32'h0);
    apb_xfer(1'b0, 14'h0008, 32'h0, r);
    check_res("abort_a1.readback", 1'b0, 14'h0008, 32'h0, r, e);

    // Alias write abandoned in A2: XOR strobe already issued, no response
    preload(8'h02, 32'h00000001);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 14'h1008; pwdata = 32'h00000003;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    check("abort_a2.strobe", 32'(rf_write_en), 32'd1);
    check("abort_a2.wdata", rf_wdata, 32'h00000002);
    ref_mem[2] = 32'h00000002;
    repeat (2) begin
      @(negedge clk);
      check("abort_a2.no_ready", 32'(pready), 32'd0);
      check("abort_a2.no_strobe", 32'(rf_write_en), 32'd0);
    end
    e = ref_xfer(1'b0, 14'h0008, 32'h0);
    apb_xfer(1'b0, 14'h0008, 32'h0, r);
    check_res("abort_a2.readback", 1'b0, 14'h0008, 32'h0, r, e);

    // Random transfers against the reference model
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [9:0] off;
      k = $urandom_range(0, 9);
      if (k < 7) begin
        k = $urandom_range(0, 39);
        if (k < 4)       off = 10'(k * 4);
        else if (k == 4) off = 10'h030;
        else if (k < 9)  off = 10'(32'h038 + (k - 5) * 4);
        else             off = 10'(32'h0C8 + (k - 9) * 4);
      end else begin
        off = 10'($urandom_range(0, 1023));
      end
      a = {2'($urandom_range(0, 3)), 2'b00, off};
      if ($urandom_range(0, 15) == 0) a[11:10] = 2'($urandom_range(1, 3));
      d  = $urandom;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) bus_idle();
      e = ref_xfer(wr, a, d);
      apb_xfer(wr, a, d, r);
      check_res($sformatf("rnd%0d", i), wr, a, d, r, e);
    end
    bus_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
